vit_decide_out: RTL and testbench

VIT_DECIDE_OUT -- requirements
Module: vit_decide_out

---
 rtl/vit_decide_out.sv | 188 ++++++++++++++++++
 tb/tb_vit_decide_out.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vit_decide_out.sv
// rtl/vit_decide_out.sv - Viterbi decision stage: winner select, warm-up gate, output FIFO.
// Optional end-of-frame flush is compiled in with `define DECIDE_FLUSH_EN.
module vit_decide_out #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [6:0] NORM_TH    = 7'd96
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sym_valid,
  input  logic [6:0]                  PM_0,
  input  logic [6:0]                  PM_1,
  input  logic [6:0]                  PM_2,
  input  logic [6:0]                  PM_3,
  input  logic [7:0]                  data_0,
  input  logic [7:0]                  data_1,
  input  logic [7:0]                  data_2,
  input  logic [7:0]                  data_3,
  input  logic                        out_ready,
`ifdef DECIDE_FLUSH_EN
  input  logic                        flush,
`endif
  output logic                        dec_bit,
  output logic                        dec_valid,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        norm_req,
  output logic                        overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] WARMUP = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
`ifdef DECIDE_FLUSH_EN
  localparam logic [1:0] FLUSH  = 2'd2;
`endif

  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  norm_q, norm_d;
  logic                  ovr_q, ovr_d;
  logic [FIFO_DEPTH-1:0] mem_q;
  logic [AW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         count_q, count_d;

  logic [6:0] win_pm;
  logic [7:0] win_data;
  logic       push, push_bit, push_ok, pop, full, room;

  // Strict less-than keeps the lowest state index on ties.
  always_comb begin
    win_pm   = PM_0;
    win_data = data_0;
    if (PM_1 < win_pm) begin
      win_pm   = PM_1;
      win_data = data_1;
    end
    if (PM_2 < win_pm) begin
      win_pm   = PM_2;
      win_data = data_2;
    end
    if (PM_3 < win_pm) begin
      win_pm   = PM_3;
      win_data = data_3;
    end
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = (count_q != '0) && out_ready;
  assign room    = !full || pop;
  assign push_ok = push && room;

`ifdef DECIDE_FLUSH_EN
  logic [6:0] fl_data_q, fl_data_d;
  logic [2:0] fl_left_q, fl_left_d;
`else
  logic unused_win_low;
  assign unused_win_low = ^win_data[6:0];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    norm_d   = norm_q;
    ovr_d    = ovr_q;
    push     = 1'b0;
    push_bit = win_data[7];
`ifdef DECIDE_FLUSH_EN
    fl_data_d = fl_data_q;
    fl_left_d = fl_left_q;
`endif
    if (sym_valid) norm_d = (win_pm >= NORM_TH);
    case (state_q)
      WARMUP: begin
        if (sym_valid) begin
          if (cnt_q == 3'd7) begin
            push    = 1'b1;
            state_d = RUN;
            cnt_d   = 3'd0;
            if (!room) ovr_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      RUN: begin
        push = sym_valid;
        if (sym_valid && !room) ovr_d = 1'b1;
`ifdef DECIDE_FLUSH_EN
        if (flush) begin
          fl_data_d = win_data[6:0];
          fl_left_d = 3'd7;
          state_d   = FLUSH;
        end
`endif
      end
`ifdef DECIDE_FLUSH_EN
      // Tail bits stall rather than drop when the FIFO is full.
      FLUSH: begin
        push     = 1'b1;
        push_bit = fl_data_q[6];
        if (sym_valid) ovr_d = 1'b1;
        if (room) begin
          fl_data_d = {fl_data_q[5:0], 1'b0};
          fl_left_d = fl_left_q - 3'd1;
          if (fl_left_q == 3'd1) begin
            state_d = WARMUP;
            cnt_d   = 3'd0;
          end
        end
      end
`endif
      default: state_d = WARMUP;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WARMUP;
      cnt_q   <= 3'd0;
      norm_q  <= 1'b0;
      ovr_q   <= 1'b0;
      mem_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      norm_q  <= norm_d;
      ovr_q   <= ovr_d;
      count_q <= count_d;
      if (push_ok) begin
        mem_q[wr_q] <= push_bit;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end

`ifdef DECIDE_FLUSH_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_data_q <= 7'd0;
      fl_left_q <= 3'd0;
    end else begin
      fl_data_q <= fl_data_d;
      fl_left_q <= fl_left_d;
    end
  end
`endif

  assign dec_valid  = (count_q != '0);
  assign dec_bit    = dec_valid & mem_q[rd_q];
  assign fifo_count = count_q;
  assign norm_req   = norm_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_vit_decide_out.sv
// tb/tb_vit_decide_out.sv - scoreboard bench for vit_decide_out.
// Flush scenarios run when DECIDE_FLUSH_EN is defined.
module tb_vit_decide_out;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sym_valid = 1'b0;
  logic [6:0] PM_0 = '0, PM_1 = '0, PM_2 = '0, PM_3 = '0;
  logic [7:0] data_0 = '0, data_1 = '0, data_2 = '0, data_3 = '0;
  logic       out_ready = 1'b0;
`ifdef DECIDE_FLUSH_EN
  logic       flush = 1'b0;
`endif
  logic       dec_bit, dec_valid, norm_req, overrun;
  logic [2:0] fifo_count;

  int vectors = 0;
  int miscompares = 0;
  logic sb[$];

  vit_decide_out #(.FIFO_DEPTH(4), .NORM_TH(7'd96)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid),
    .PM_0(PM_0), .PM_1(PM_1), .PM_2(PM_2), .PM_3(PM_3),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .out_ready(out_ready),
`ifdef DECIDE_FLUSH_EN
    .flush(flush),
`endif
    .dec_bit(dec_bit), .dec_valid(dec_valid), .fifo_count(fifo_count),
    .norm_req(norm_req), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout reached before summary");
    $fatal(1, "timeout");
  end

  // Pops happen on the next rising edge; compare the head half a cycle earlier.
  always @(negedge clk) begin
    if (!rst && dec_valid && out_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output dec_bit=%b, none expected", dec_bit);
      end else begin
        logic e;
        e = sb.pop_front();
        if (dec_bit !== e) begin
          miscompares++;
          $display("FAIL output_order dec_bit=%b expected %b", dec_bit, e);
        end
      end
    end
  end

  function automatic logic ref_bit(input logic [6:0] p0, p1, p2, p3,
                                   input logic [7:0] d0, d1, d2, d3);
    logic [6:0] m;
    logic       b;
    m = p0; b = d0[7];
    if (p1 < m) begin m = p1; b = d1[7]; end
    if (p2 < m) begin m = p2; b = d2[7]; end
    if (p3 < m) begin m = p3; b = d3[7]; end
    return b;
  endfunction

  task automatic sym(input logic [6:0] p0, p1, p2, p3, input logic [7:0] d0, d1, d2, d3,
                     input bit pushed, input logic exp);
    PM_0 = p0; PM_1 = p1; PM_2 = p2; PM_3 = p3;
    data_0 = d0; data_1 = d1; data_2 = d2; data_3 = d3;
    sym_valid = 1'b1;
    if (pushed) sb.push_back(exp);
    @(posedge clk); #1;
    sym_valid = 1'b0;
  endtask

  task automatic sym1(input logic b, input bit pushed);
    sym(7'd10, 7'd10, 7'd10, 7'd10, {b, 7'h15}, 8'h00, 8'hFF, 8'h00, pushed, b);
  endtask

  task automatic idle(input int n);
    sym_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((dec_valid || sb.size() != 0) && n < 64) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (dec_valid || sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain fifo_count=%0d pending=%0d expected 0 and 0", fifo_count, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    vectors++;
    if ({dec_valid, dec_bit, fifo_count, norm_req, overrun} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_in dv=%b db=%b cnt=%0d norm=%b ovr=%b expected all 0",
               dec_valid, dec_bit, fifo_count, norm_req, overrun);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({dec_valid, dec_bit, fifo_count, norm_req, overrun} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_out dv=%b cnt=%0d norm=%b ovr=%b expected all 0",
               dec_valid, fifo_count, norm_req, overrun);
    end
  endtask

  task automatic test_warmup();
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sym1(1'b1, 1'b0);
      vectors++;
      if (dec_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL warmup_discard sym=%0d dec_valid=%b expected 0", i, dec_valid);
      end
    end
    sym1(1'b1, 1'b1);
    vectors++;
    if (dec_valid !== 1'b1 || dec_bit !== 1'b1 || fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL warmup_eighth dv=%b db=%b cnt=%0d expected 1 1 1", dec_valid, dec_bit, fifo_count);
    end
    wait_drain();
  endtask

  task automatic test_winner();
    out_ready = 1'b1;
    sym(7'd5, 7'd3, 7'd3, 7'd9, 8'h00, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1);
    sym(7'd4, 7'd4, 7'd4, 7'd4, 8'h00, 8'h80, 8'h80, 8'h80, 1'b1, 1'b0);
    sym(7'd9, 7'd9, 7'd9, 7'd2, 8'h00, 8'h00, 8'h00, 8'h80, 1'b1, 1'b1);
    sym(7'd7, 7'd6, 7'd7, 7'd6, 8'h80, 8'h00, 8'h80, 8'h80, 1'b1, 1'b0);
    sym(7'd0, 7'd0, 7'd1, 7'd1, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    logic [6:0] p[4];
    logic [7:0] d[4];
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < 4; k++) begin
        p[k] = 7'($urandom_range(0, 40));
        d[k] = 8'($urandom);
      end
      sym(p[0], p[1], p[2], p[3], d[0], d[1], d[2], d[3], 1'b1,
          ref_bit(p[0], p[1], p[2], p[3], d[0], d[1], d[2], d[3]));
    end
    wait_drain();
  endtask

  task automatic test_empty_push_pop();
    out_ready = 1'b1;
    sym1(1'b1, 1'b1);
    vectors++;
    if (dec_valid !== 1'b1 || fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL empty_push_pop dv=%b cnt=%0d expected 1 1", dec_valid, fifo_count);
    end
    wait_drain();
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    sym1(1'b1, 1'b1);
    sym1(1'b0, 1'b1);
    sym1(1'b1, 1'b1);
    sym1(1'b1, 1'b1);
    vectors++;
    if (fifo_count !== 3'd4 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_four cnt=%0d ovr=%b expected 4 0", fifo_count, overrun);
    end
    sym1(1'b0, 1'b0);
    vectors++;
    if (fifo_count !== 3'd4 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_drop cnt=%0d ovr=%b expected 4 1", fifo_count, overrun);
    end
    out_ready = 1'b1;
    sym1(1'b0, 1'b1);
    vectors++;
    if (fifo_count !== 3'd4) begin
      miscompares++;
      $display("FAIL full_push_pop cnt=%0d expected 4", fifo_count);
    end
    wait_drain();
  endtask

  task automatic test_norm();
    out_ready = 1'b1;
    sym(7'd95, 7'd100, 7'd120, 7'd127, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    vectors++;
    if (norm_req !== 1'b0) begin
      miscompares++;
      $display("FAIL norm_95 norm_req=%b expected 0", norm_req);
    end
    sym(7'd120, 7'd96, 7'd110, 7'd127, 8'h00, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1);
    vectors++;
    if (norm_req !== 1'b1) begin
      miscompares++;
      $display("FAIL norm_96 norm_req=%b expected 1", norm_req);
    end
    PM_0 = 7'd0; PM_1 = 7'd0; PM_2 = 7'd0; PM_3 = 7'd0;
    idle(2);
    vectors++;
    if (norm_req !== 1'b1) begin
      miscompares++;
      $display("FAIL norm_hold norm_req=%b expected 1", norm_req);
    end
    sym(7'd10, 7'd100, 7'd100, 7'd100, 8'h80, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    vectors++;
    if (norm_req !== 1'b0) begin
      miscompares++;
      $display("FAIL norm_clear norm_req=%b expected 0", norm_req);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    sym1(1'b1, 1'b1);
    sym1(1'b0, 1'b1);
    sym1(1'b1, 1'b1);
    vectors++;
    if (fifo_count !== 3'd3) begin
      miscompares++;
      $display("FAIL pre_reset cnt=%0d expected 3", fifo_count);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({dec_valid, dec_bit, fifo_count, norm_req, overrun} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid dv=%b db=%b cnt=%0d norm=%b ovr=%b expected all 0",
               dec_valid, dec_bit, fifo_count, norm_req, overrun);
    end
    sb.delete();
    #4 rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sym1(1'b1, 1'b0);
      vectors++;
      if (dec_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rewarmup sym=%0d dec_valid=%b expected 0", i, dec_valid);
      end
    end
    sym1(1'b0, 1'b1);
    wait_drain();
  endtask

`ifdef DECIDE_FLUSH_EN
  task automatic test_flush();
    logic [7:0] a5;
    a5 = 8'hA5;
    out_ready = 1'b1;
    PM_0 = 7'd10; PM_1 = 7'd20; PM_2 = 7'd20; PM_3 = 7'd20;
    data_0 = a5; data_1 = 8'h00; data_2 = 8'h00; data_3 = 8'h00;
    sym_valid = 1'b1; flush = 1'b1;
    sb.push_back(a5[7]);
    for (int i = 6; i >= 0; i--) sb.push_back(a5[i]);
    @(posedge clk); #1;
    sym_valid = 1'b0; flush = 1'b0;
    wait_drain();
    for (int i = 0; i < 7; i++) begin
      if (i == 2) flush = 1'b1;
      sym1(1'b1, 1'b0);
      flush = 1'b0;
      vectors++;
      if (dec_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_to_warmup sym=%0d dec_valid=%b expected 0", i, dec_valid);
      end
    end
    sym1(1'b1, 1'b1);
    wait_drain();
  endtask

  task automatic test_flush_stall();
    logic [7:0] v;
    v = 8'h3C;
    out_ready = 1'b0;
    PM_0 = 7'd10; PM_1 = 7'd20; PM_2 = 7'd20; PM_3 = 7'd20;
    data_0 = v;
    flush = 1'b1;
    for (int i = 6; i >= 0; i--) sb.push_back(v[i]);
    @(posedge clk); #1;
    flush = 1'b0;
    idle(8);
    vectors++;
    if (fifo_count !== 3'd4 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_stall cnt=%0d ovr=%b expected 4 0", fifo_count, overrun);
    end
    sym1(1'b1, 1'b0);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_sym_overrun ovr=%b expected 1", overrun);
    end
    wait_drain();
    for (int i = 0; i < 7; i++) sym1(1'b0, 1'b0);
    out_ready = 1'b0;
    sym1(1'b1, 1'b1);
    sym1(1'b0, 1'b1);
    sym1(1'b1, 1'b1);
    data_0 = 8'hFF;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    idle(2);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({dec_valid, dec_bit, fifo_count, norm_req, overrun} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_mid_flush dv=%b cnt=%0d ovr=%b expected all 0", dec_valid, fifo_count, overrun);
    end
    sb.delete();
    #4 rst = 1'b0;
    out_ready = 1'b1;
    idle(20);
    vectors++;
    if (dec_valid !== 1'b0 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL after_flush_reset dv=%b cnt=%0d expected 0 0", dec_valid, fifo_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_warmup();
    test_winner();
    test_back_to_back();
    test_empty_push_pop();
    test_overrun();
    test_norm();
    test_reset_mid();
`ifdef DECIDE_FLUSH_EN
    test_flush();
    test_flush_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
